fetch_queue: RTL

Instruction-side consumer of the program counter. Each cycle it takes the PC presented by the PC generator and issues it to the synchronous instruction ROM. It queues the returned 9-bit instructions, tagged with their PC, in a small FIFO toward decode. It drives `Stall` back to the PC generator when the queue cannot absorb another fetch, and flushes wrong-path instructions on `Branch`.

---
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue.sv | 100 ++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the PC generator / instruction ROM and decode for fetch_queue.
interface fetch_queue_if #(
    parameter int AW = 8,
    parameter int IW = 9
);
    logic [AW-1:0] PC;
    logic          Branch;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          Stall;

    modport master (
        input  PC, Branch, done, rom_data, instr_ready,
        output rom_addr, instr, instr_pc, instr_valid, Stall
    );

    modport slave (
        output PC, Branch, done, rom_data, instr_ready,
        input  rom_addr, instr, instr_pc, instr_valid, Stall
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetches each presented PC from a synchronous ROM and queues PC-tagged instructions toward decode.
// Optional empty-queue bypass of the ROM response to the head: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 9,
    parameter int AW    = 8
) (
    input  logic          CLK,
    input  logic          Init,
    fetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [IW-1:0] mem_instr_r [DEPTH];
    logic [AW-1:0] mem_pc_r    [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          req_valid_r;
    logic [AW-1:0] req_pc_r;

    logic          stall_s;
    logic          issue_s;
    logic          fifo_empty_s;
    logic          head_valid_s;
    logic          fifo_pop_s;
    logic          push_s;
    logic [CW:0]   occupancy_s;
    logic [IW-1:0] instr_s;
    logic [AW-1:0] instr_pc_s;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Stall/issue decision, head selection and push/pop qualification
    always_comb begin
        // Stall is conservative: it counts the in-flight response but not a same-cycle pop
        occupancy_s  = {1'b0, count_r} + {{CW{1'b0}}, req_valid_r};
        stall_s      = !bus.Branch && (occupancy_s >= DEPTH_W);
        issue_s      = !Init && !bus.done && !stall_s && !bus.Branch;
        fifo_empty_s = (count_r == '0);
        fifo_pop_s   = !fifo_empty_s && bus.instr_ready;
        head_valid_s = !fifo_empty_s;
        instr_s      = mem_instr_r[rd_ptr_r];
        instr_pc_s   = mem_pc_r[rd_ptr_r];
        push_s       = req_valid_r && !bus.Branch;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (fifo_empty_s && req_valid_r && !bus.Branch) begin
            head_valid_s = 1'b1;
            instr_s      = bus.rom_data;
            instr_pc_s   = req_pc_r;
            push_s       = !bus.instr_ready;
        end else begin
            head_valid_s = !fifo_empty_s;
        end
`endif
    end

    assign bus.rom_addr    = bus.PC;
    assign bus.Stall       = stall_s;
    assign bus.instr_valid = head_valid_s;
    assign bus.instr       = head_valid_s ? instr_s : '0;
    assign bus.instr_pc    = head_valid_s ? instr_pc_s : '0;

    // Pointers, occupancy and the in-flight request; Init and Branch both flush
    always_ff @(posedge CLK) begin
        if (Init || bus.Branch) begin
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            req_valid_r <= 1'b0;
            req_pc_r    <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            count_r     <= count_r + CW'(push_s) - CW'(fifo_pop_s);
            req_valid_r <= issue_s;
            req_pc_r    <= bus.PC;
        end
    end

    // Queue storage; contents are only meaningful below the count, so no reset
    always_ff @(posedge CLK) begin
        if (!Init && push_s) begin
            mem_instr_r[wr_ptr_r] <= bus.rom_data;
            mem_pc_r[wr_ptr_r]    <= req_pc_r;
        end
    end
endmodule
